matrix_operand_loader: RTL
==========================

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max cycles in WAIT awaiting DONE (legal 2..255).
REQ-002 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port IN_DATA  input  8  operand byte; frame order a00,a01,a02,a10..a22 then b00..b22, row-major.
REQ-005 SHALL have port IN_VALID  input  1  IN_DATA/IN_LAST valid.
REQ-006 SHALL have port IN_LAST  input  1  marks final byte of a frame.
REQ-007 SHALL have port IN_READY  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have ports a00..a22, b00..b22  output  8 each  committed operands to systolic array.
REQ-009 SHALL have port START  output  1  registered one-cycle job start to array.
REQ-010 SHALL have port DONE  input  1  job-complete from array.
REQ-011 SHALL have ports BUSY, FRAME_ERR, TIMEOUT  output  1 each  job in flight / one-cycle error pulses.

Function
REQ-012 SHALL accept a byte on every edge where IN_VALID and IN_READY are both 1, writing it to staging slot idx (0..17), then idx+1.
REQ-013 SHALL run FSM LOAD -> COMMIT -> FIRE -> WAIT -> LOAD; BUSY=1 in every state except LOAD.
REQ-014 SHALL, in LOAD, drive IN_READY=1 unless the staging frame is complete.
REQ-015 SHALL, on acceptance of slot 17 with IN_LAST=1, mark staging full, reset idx to 0, and enter COMMIT.
REQ-016 SHALL treat IN_LAST=1 on slot<17, or IN_LAST=0 on slot 17, as a frame error: pulse FRAME_ERR one cycle, reset idx to 0, discard staging, leave committed operands and START untouched.
REQ-017 SHALL, in COMMIT, copy all 18 staging bytes to the operand outputs in one edge, clear staging full, and go to FIRE.
REQ-018 SHALL drive START=1 during exactly the FIRE cycle, then enter WAIT; latency is last byte accepted at edge k, operands updated at edge k+1, START high between edges k+2 and k+3.
REQ-019 SHALL hold operand outputs constant from COMMIT until the next COMMIT.
REQ-020 SHALL, in WAIT, count cycles from 0; DONE=1 -> LOAD; count reaching TIMEOUT_CYC-1 without DONE -> pulse TIMEOUT one cycle, go to LOAD.
REQ-021 SHALL give DONE priority over timeout in the same cycle, and ignore DONE outside WAIT.
REQ-022 SHALL ignore IN_DATA and IN_LAST while IN_READY=0; bytes are never dropped or duplicated.

Reset
REQ-023 SHALL, on RESET=1, set state LOAD, idx 0, staging full 0, wait counter 0, all operand outputs 0x00, and START, FRAME_ERR, TIMEOUT and BUSY to 0; IN_READY=1 on the first cycle after reset.
REQ-024 SHALL abandon any partial frame or in-flight job on RESET asserted mid-operation; no START is issued for it.

Configuration
REQ-025 SHALL support macro MATRIX_LOADER_DBUF_EN; when defined, IN_READY stays 1 in COMMIT, FIRE and WAIT while staging is not full, so the next frame loads during compute.
REQ-026 SHALL, with MATRIX_LOADER_DBUF_EN defined and staging full at WAIT exit (DONE or timeout), go directly to COMMIT instead of LOAD.
REQ-027 SHALL, without MATRIX_LOADER_DBUF_EN, hold IN_READY=0 in every state except LOAD.

Structure
REQ-028 SHALL place the state enum, FRAME_LEN=18, LAST_IDX=17 and DATA_W=8 in shared package systolic_loader_pkg.
REQ-029 SHALL implement staging plus committed storage in one sub-module, loader_operand_bank (write-slot port, bulk-commit port, 18 outputs); the FSM stays in the top module.

Verification
REQ-030 SHALL test a good frame of values 1..18 -> a00=1, a22=9, b00=10, b22=18, START one cycle at edge k+2, BUSY=1 until DONE.
REQ-031 SHALL test IN_LAST on byte 5 -> FRAME_ERR pulse, no START, outputs unchanged, next good frame commits normally.
REQ-032 SHALL test the array never asserting DONE with TIMEOUT_CYC=8 -> TIMEOUT pulses after 8 WAIT cycles, then LOAD with IN_READY=1.
REQ-033 SHALL test DONE and the timeout terminal count in the same cycle -> no TIMEOUT pulse, state LOAD.
REQ-034 SHALL test RESET asserted at byte 9 and held mid-WAIT -> all outputs 0x00, idx 0, no START.
REQ-035 SHALL test with MATRIX_LOADER_DBUF_EN defined, a second frame (values 0x20..0x31) sent during WAIT -> IN_READY falls after 18 bytes, DONE -> COMMIT, a00=0x20, START follows without returning to LOAD.

Source files
------------

// File: rtl/systolic_loader_pkg.sv
// Shared types and frame geometry for the matrix operand loader.
package systolic_loader_pkg;

    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 18;
    localparam int LAST_IDX  = 17;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMMIT,
        ST_FIRE,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/loader_operand_bank.sv
// Staging buffer (byte-wise writes) plus committed operand registers (bulk copy).
module loader_operand_bank
    import systolic_loader_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              commit_i,
    output logic [DATA_W-1:0] op_o [FRAME_LEN]
);

    logic [DATA_W-1:0] stage_q [FRAME_LEN];
    logic [DATA_W-1:0] op_q    [FRAME_LEN];

    // NOTE: staging is deliberately not reset -- every slot is rewritten before a
    // frame can be committed, so a reset here would only cost muxes.
    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            stage_q[wr_idx_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking assignments keep the bulk copy reading the pre-edge staging values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                op_q[i] <= '0;
            end
        end else if (commit_i) begin
            op_q <= stage_q;
        end
    end

    assign op_o = op_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams 18 operand bytes into staging, commits them to the array and runs one job.
// Optional macro MATRIX_LOADER_DBUF_EN lets the next frame load while a job is in flight.
module matrix_operand_loader
    import systolic_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    input  logic              IN_LAST,
    output logic              IN_READY,
    output logic [DATA_W-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22,
    output logic [DATA_W-1:0] b00, b01, b02, b10, b11, b12, b20, b21, b22,
    output logic              START,
    input  logic              DONE,
    output logic              BUSY,
    output logic              FRAME_ERR,
    output logic              TIMEOUT
);

    state_t            state_q, state_d, wait_exit_state;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              full_q, full_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              start_q, start_d;
    logic              ferr_q, ferr_d;
    logic              tmo_q, tmo_d;
    logic              commit_en;
    logic [DATA_W-1:0] op [FRAME_LEN];

    logic accept, last_slot, good_last, bad_frame, tmo_hit;

    assign accept    = IN_VALID && IN_READY;
    assign last_slot = (idx_q == IDX_W'(LAST_IDX));
    assign good_last = accept && IN_LAST && last_slot;
    assign bad_frame = accept && (IN_LAST != last_slot);
    assign tmo_hit   = (state_q == ST_WAIT) && !DONE && (cnt_q == 8'(TIMEOUT_CYC - 1));

`ifdef MATRIX_LOADER_DBUF_EN
    // A frame completed during the job goes straight to commit.
    assign wait_exit_state = full_d ? ST_COMMIT : ST_LOAD;
`else
    assign wait_exit_state = ST_LOAD;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (good_last) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_FIRE;
            ST_FIRE:   state_d = ST_WAIT;
            ST_WAIT:   if (DONE || tmo_hit) state_d = wait_exit_state;
            default:   state_d = ST_LOAD;
        endcase
    end

    always_comb begin
`ifdef MATRIX_LOADER_DBUF_EN
        IN_READY  = !full_q;
`else
        IN_READY  = (state_q == ST_LOAD) && !full_q;
`endif
        BUSY      = (state_q != ST_LOAD);
        commit_en = (state_q == ST_COMMIT);
    end

    always_comb begin
        idx_d   = idx_q;
        full_d  = full_q;
        cnt_d   = '0;
        start_d = (state_q == ST_FIRE);
        ferr_d  = bad_frame;
        tmo_d   = tmo_hit;
        if (commit_en) begin
            full_d = 1'b0;
        end
        if (accept) begin
            if (good_last) begin
                full_d = 1'b1;
                idx_d  = '0;
            end else if (bad_frame) begin
                idx_d  = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
            end
        end
        if ((state_q == ST_WAIT) && !(DONE || tmo_hit)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q   <= '0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ferr_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ferr_q  <= ferr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign START     = start_q;
    assign FRAME_ERR = ferr_q;
    assign TIMEOUT   = tmo_q;

    loader_operand_bank u_bank (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr_en_i   (accept),
        .wr_idx_i  (idx_q),
        .wr_data_i (IN_DATA),
        .commit_i  (commit_en),
        .op_o      (op)
    );

    assign a00 = op[0];  assign a01 = op[1];  assign a02 = op[2];
    assign a10 = op[3];  assign a11 = op[4];  assign a12 = op[5];
    assign a20 = op[6];  assign a21 = op[7];  assign a22 = op[8];
    assign b00 = op[9];  assign b01 = op[10]; assign b02 = op[11];
    assign b10 = op[12]; assign b11 = op[13]; assign b12 = op[14];
    assign b20 = op[15]; assign b21 = op[16]; assign b22 = op[17];

endmodule
